// File: rtl/dl_or_accum_if.sv
// Stream bundle for the OR-accumulator: beat input channel and result output channel.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface dl_or_accum_if #(
    parameter int NUM_BITS  = 8,
    parameter int MAX_BEATS = 16
);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    logic                in_valid;
    logic                in_ready;
    logic [NUM_BITS-1:0] in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [NUM_BITS-1:0] out_data;
    logic [CNT_W-1:0]    out_beats;
    logic                out_trunc;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_beats, out_trunc
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_beats, out_trunc
    );
endinterface

// File: rtl/dl_or_accum.sv
// Streaming OR-accumulator: ORs all beats of a packet into one registered result beat
// carrying the OR word, the beat count and a flag for packets cut off at MAX_BEATS.
module dl_or_accum #(
    parameter int NUM_BITS  = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst,
    dl_or_accum_if.slave     bus
);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    logic [NUM_BITS-1:0] acc;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;
    logic [NUM_BITS-1:0] acc_or;
    logic [NUM_BITS-1:0] res_data;
    logic [CNT_W-1:0]    res_beats;
    logic                res_trunc;
    logic                res_valid;
    logic                ready;
    logic                accept;
    logic                terminate;

    // Input stalls only while a result is waiting on a stalled downstream.
    assign ready     = ~res_valid | bus.out_ready;
    assign accept    = bus.in_valid & ready;
    assign cnt_inc   = cnt + CNT_W'(1);
    assign acc_or    = acc | bus.in_data;
    assign terminate = accept & (bus.in_last | (cnt_inc == CNT_W'(MAX_BEATS)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            res_data  <= '0;
            res_beats <= '0;
            res_trunc <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            if (terminate) begin
                res_data  <= acc_or;
                res_beats <= cnt_inc;
                res_trunc <= ~bus.in_last;
                res_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
            end else begin
                if (accept) begin
                    acc <= acc_or;
                    cnt <= cnt_inc;
                end
                if (res_valid && bus.out_ready) begin
                    res_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = res_valid;
    assign bus.out_data  = res_data;
    assign bus.out_beats = res_beats;
    assign bus.out_trunc = res_trunc;
endmodule
